weight_fetch_unit: RTL and testbench
====================================

WEIGHT_FETCH_UNIT -- requirements
Module: weight_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request/write address width (>=26).
REQ-002 SHALL have parameter DATA_W, default 32, data word width (multiple of 8).
REQ-003 SHALL have parameter K3_LEN, default 144, words of 3x3 weights per output channel (1..65535).
REQ-004 SHALL have parameter K1_LEN, default 16, words of 1x1 weights per output channel (1..65535).
REQ-005 SHALL have parameter MAX_OUTST, default 4, maximum requests in flight (1..15).
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset; one clock, all logic on rising edge of clk.
REQ-007 SHALL have ports: weight_start  in  1  start pulse; weight_mode  in  2  01=3x3 only, 10=1x1 only, 11=both, 00=illegal; out_ch_cnt  in  8  output-channel index.
REQ-008 SHALL have ports: weight3_base_addr  in  ADDR_W  3x3 byte base; weight1_base_addr  in  ADDR_W  1x1 byte base.
REQ-009 SHALL have ports: weight_busy  out  1  job active; weight_done  out  1  completion pulse; weight_err  out  1  sticky protocol error.
REQ-010 SHALL have ports: req_addr  out  ADDR_W  byte address; req_vld  out  1; req_rdy  in  1.
REQ-011 SHALL have ports: rsp_data  in  DATA_W; rsp_vld  in  1; rsp_rdy  out  1  constant 1.
REQ-012 SHALL have ports: weight_wen  out  1; weight_waddr  out  ADDR_W; weight_wdata  out  DATA_W.

Function
REQ-013 SHALL implement states IDLE, FETCH3, FETCH1, DRAIN.
REQ-014 IDLE: weight_start with mode 11/01 -> FETCH3; mode 10 -> FETCH1; mode 00 -> stay IDLE, set weight_err; config inputs latched on the accepted start cycle.
REQ-015 weight_start while weight_busy SHALL be ignored; weight_busy=1 in every state except IDLE.
REQ-016 FETCH3 first address = weight3_base_addr + out_ch_cnt*K3_LEN*(DATA_W/8); FETCH1 first address = weight1_base_addr + out_ch_cnt*K1_LEN*(DATA_W/8); both modulo 2^ADDR_W.
REQ-017 Each accepted request (req_vld & req_rdy) SHALL advance req_addr by DATA_W/8 and the issue counter by 1.
REQ-018 req_vld SHALL be 1 only in FETCH3/FETCH1 when issued<segment length and outstanding<MAX_OUTST; req_addr and req_vld stable while req_vld & !req_rdy.
REQ-019 FETCH3 -> FETCH1 (mode 11) or DRAIN (mode 01) on acceptance of request K3_LEN; FETCH1 -> DRAIN on acceptance of request K1_LEN; issue counter cleared on transition.
REQ-020 outstanding counter: +1 per accepted request, -1 per accepted response, unchanged if both same cycle; never exceeds MAX_OUTST.
REQ-021 Responses in order; weight_wen = rsp_vld & busy; weight_wdata = rsp_data, same cycle (zero latency).
REQ-022 weight_waddr = {type, out_ch_cnt, zeros, word_idx[15:0]}; type bit [ADDR_W-1]=0 for 3x3 responses, 1 for 1x1; word_idx restarts at 0 per segment.
REQ-023 DRAIN -> IDLE when final response accepted; weight_done=1 exactly one cycle, the cycle after that response.
REQ-024 rsp_vld in IDLE SHALL not assert weight_wen and SHALL set weight_err; weight_err cleared only by reset or an accepted legal weight_start.

Reset
REQ-025 rst=1 at any rising clk edge, including mid-job, SHALL force state IDLE and clear all counters.
REQ-026 Reset values: req_vld=0, req_addr=0, weight_busy=0, weight_done=0, weight_err=0, weight_wen=0, weight_waddr=0, stall_cycles=0.
REQ-027 Responses arriving after a mid-job reset SHALL be treated as in REQ-024.

Configuration
REQ-028 Macro WEIGHT_FETCH_STALL_CNT_EN defined: output stall_cycles (32 bits) counts cycles with req_vld & !req_rdy, cleared on accepted start, saturates at all ones.
REQ-029 Macro undefined: stall_cycles port and counter absent; all other behaviour identical.

Verification
REQ-030 Defaults, mode 11, out_ch_cnt=2, bases 0x1000/0x8000, req_rdy=1, 1-cycle response -> first req_addr 0x1480, 144 type-0 writes, first 1x1 req_addr 0x8080, 16 type-1 writes, done once.
REQ-031 mode 10, K1_LEN=16, responses delayed 10 cycles -> req_vld drops with 4 outstanding, never 5; 16 writes word_idx 0..15.
REQ-032 req_rdy held 0 for 5 cycles mid-FETCH3 -> req_addr unchanged those cycles; with macro, stall_cycles=5.
REQ-033 mode 00 start -> busy stays 0, weight_err=1, no requests; later legal start clears err.
REQ-034 rst pulsed after 20 requests accepted -> next cycle IDLE, req_vld=0; late rsp_vld -> no wen, err=1.
REQ-035 weight_start re-pulsed during FETCH1 -> ignored, exactly 160 writes and one done pulse.

Source files
------------

// File: rtl/weight_fetch_unit.sv
// -----------------------------------------------------------------------------
// weight_fetch_unit
//
// Purpose
//   Fetches one output channel's convolution weights from memory and writes
//   them into the local weight buffer. A job fetches a 3x3 segment (K3_LEN
//   words), a 1x1 segment (K1_LEN words), or the 3x3 segment followed by the
//   1x1 segment. Up to MAX_OUTST requests may be in flight. Responses come
//   back in order and are written to the buffer in the same cycle.
//
// Optional feature
//   WEIGHT_FETCH_STALL_CNT_EN : when defined, adds the 32-bit output
//   stall_cycles. It counts cycles with req_vld & !req_rdy, is cleared on an
//   accepted start and saturates at all ones. When undefined, the port and
//   the counter are absent.
//
// Handshake semantics (request and response channels)
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   The source holds valid and its payload stable until that transfer. The
//   sink may raise or drop ready in any cycle. rsp_rdy is always 1, so every
//   rsp_vld cycle is one accepted response.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   weight_start             start pulse (ignored while weight_busy)
//   weight_mode[1:0]         01=3x3 only, 10=1x1 only, 11=both, 00=illegal
//   out_ch_cnt[7:0]          output-channel index
//   weight3/1_base_addr      byte base addresses of the 3x3 / 1x1 weights
//   weight_busy              job active (state != IDLE)
//   weight_done              one-cycle pulse after the final response
//   weight_err               sticky protocol error
//   req_addr, req_vld, req_rdy          read request channel
//   rsp_data, rsp_vld, rsp_rdy          in-order read response channel
//   weight_wen, weight_waddr, weight_wdata   buffer write port
//   stall_cycles[31:0]       request stall counter (optional, see above)
//   state_dbg[1:0]           current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module weight_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int K3_LEN    = 144,
  parameter int K1_LEN    = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              weight_start,
  input  logic [1:0]        weight_mode,
  input  logic [7:0]        out_ch_cnt,
  input  logic [ADDR_W-1:0] weight3_base_addr,
  input  logic [ADDR_W-1:0] weight1_base_addr,
  output logic              weight_busy,
  output logic              weight_done,
  output logic              weight_err,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_vld,
  input  logic              req_rdy,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_vld,
  output logic              rsp_rdy,
  output logic              weight_wen,
  output logic [ADDR_W-1:0] weight_waddr,
  output logic [DATA_W-1:0] weight_wdata,
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic [1:0]        state_dbg
);

  localparam int                BYTES     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] STRIDE3   = ADDR_W'(K3_LEN * BYTES);
  localparam logic [ADDR_W-1:0] STRIDE1   = ADDR_W'(K1_LEN * BYTES);
  localparam logic [15:0]       LAST3     = 16'(K3_LEN - 1);
  localparam logic [15:0]       LAST1     = 16'(K1_LEN - 1);
  localparam logic [3:0]        OUTST_MAX = 4'(MAX_OUTST);
  // Zero field between the channel index and the 16-bit word index.
  localparam int                PAD_W     = ADDR_W - 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH3 = 2'd1,
    FETCH1 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [7:0]        ch_q;
  logic [ADDR_W-1:0] addr1_first;   // 1x1 start address, kept for mode 11
  logic [15:0]       issued;        // requests accepted in current segment
  logic [3:0]        outst;         // requests accepted but not yet answered
  logic              rsp_type;      // segment of the next response: 0=3x3, 1=1x1
  logic [15:0]       rsp_idx;       // word index of the next response

  logic              fetching;
  logic [15:0]       seg_last;
  logic              req_fire;
  logic              seg_end;
  logic              rsp_fire;
  logic              rsp_dec;
  logic              rsp_seg_end;
  logic              start_ok;
  logic [ADDR_W-1:0] first3;
  logic [ADDR_W-1:0] first1;

  assign weight_busy = (state != IDLE);
  assign state_dbg   = state;
  assign fetching    = (state == FETCH3) || (state == FETCH1);
  assign seg_last    = (state == FETCH3) ? LAST3 : LAST1;

  // req_vld depends only on registers, and outst can only fall while a
  // request waits, so an offered request stays offered until it is taken.
  assign req_vld  = fetching && (issued <= seg_last) && (outst < OUTST_MAX);
  assign req_fire = req_vld && req_rdy;
  assign seg_end  = req_fire && (issued == seg_last);

  assign rsp_rdy     = 1'b1;
  assign rsp_fire    = rsp_vld && weight_busy;
  // A response with nothing outstanding must not wrap the counter.
  assign rsp_dec     = rsp_fire && (outst != 4'd0);
  assign rsp_seg_end = rsp_type ? (rsp_idx == LAST1) : (rsp_idx == LAST3);

  assign start_ok = (state == IDLE) && weight_start && (weight_mode != 2'b00);
  assign first3   = weight3_base_addr + ADDR_W'(out_ch_cnt) * STRIDE3;
  assign first1   = weight1_base_addr + ADDR_W'(out_ch_cnt) * STRIDE1;

  // Buffer write is a zero-latency pass-through of the response.
  assign weight_wen   = rsp_fire;
  assign weight_wdata = rsp_data;
  assign weight_waddr = rsp_fire ? {rsp_type, ch_q, {PAD_W{1'b0}}, rsp_idx}
                                 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= 2'b00;
      ch_q        <= 8'd0;
      addr1_first <= '0;
      req_addr    <= '0;
      issued      <= 16'd0;
      outst       <= 4'd0;
      rsp_type    <= 1'b0;
      rsp_idx     <= 16'd0;
      weight_done <= 1'b0;
      weight_err  <= 1'b0;
    end else begin
      weight_done <= 1'b0;

      case (state)
        IDLE: begin
          if (weight_start && (weight_mode == 2'b00)) begin
            weight_err <= 1'b1;
          end
          if (start_ok) begin
            weight_err  <= 1'b0;
            mode_q      <= weight_mode;
            ch_q        <= out_ch_cnt;
            addr1_first <= first1;
            issued      <= 16'd0;
            outst       <= 4'd0;
            rsp_idx     <= 16'd0;
            if (weight_mode == 2'b10) begin
              state    <= FETCH1;
              req_addr <= first1;
              rsp_type <= 1'b1;
            end else begin
              state    <= FETCH3;
              req_addr <= first3;
              rsp_type <= 1'b0;
            end
          end
          // A response with no job running is a protocol error; it is
          // listed last so it wins over a same-cycle legal start.
          if (rsp_vld) begin
            weight_err <= 1'b1;
          end
        end

        FETCH3, FETCH1: begin
          if (req_fire) begin
            if (seg_end) begin
              issued <= 16'd0;
              if ((state == FETCH3) && (mode_q == 2'b11)) begin
                state    <= FETCH1;
                req_addr <= addr1_first;
              end else begin
                state    <= DRAIN;
                req_addr <= req_addr + STEP;
              end
            end else begin
              issued   <= issued + 16'd1;
              req_addr <= req_addr + STEP;
            end
          end
        end

        default: begin
        end
      endcase

      if (req_fire && !rsp_dec) begin
        outst <= outst + 4'd1;
      end else if (!req_fire && rsp_dec) begin
        outst <= outst - 4'd1;
      end

      // Responses follow request order, so the write-side segment and index
      // are tracked independently of the request side. The final response
      // can only arrive in DRAIN because the last request is already issued.
      if (rsp_fire) begin
        if (rsp_seg_end) begin
          rsp_idx <= 16'd0;
          if (!rsp_type && (mode_q == 2'b11)) begin
            rsp_type <= 1'b1;
          end else begin
            state       <= IDLE;
            weight_done <= 1'b1;
          end
        end else begin
          rsp_idx <= rsp_idx + 16'd1;
        end
      end
    end
  end

`ifdef WEIGHT_FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (start_ok) begin
      stall_cycles <= 32'd0;
    end else if (req_vld && !req_rdy && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_weight_fetch_unit
//
// Self-checking bench for weight_fetch_unit. Each job start pushes the full
// expected request address sequence into exp_req_q. The responder pushes the
// expected buffer write ({waddr, wdata}) into exp_wr_q as it drives each
// response. A negedge monitor pops and compares whenever the DUT accepts a
// request or asserts weight_wen. Directed scenarios cover the reference job,
// outstanding limit, request stall, illegal mode, mid-job reset and an
// ignored re-start; randomized jobs follow.
// -----------------------------------------------------------------------------
module tb_weight_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int K3     = 144;
  localparam int K1     = 16;
  localparam int MAXO   = 4;
  localparam int BYTES  = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic              weight_start;
  logic [1:0]        weight_mode;
  logic [7:0]        out_ch_cnt;
  logic [ADDR_W-1:0] weight3_base_addr;
  logic [ADDR_W-1:0] weight1_base_addr;
  logic              weight_busy;
  logic              weight_done;
  logic              weight_err;
  logic [ADDR_W-1:0] req_addr;
  logic              req_vld;
  logic              req_rdy;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic              weight_wen;
  logic [ADDR_W-1:0] weight_waddr;
  logic [DATA_W-1:0] weight_wdata;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif
  logic [1:0]        state_dbg;

  weight_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .K3_LEN(K3), .K1_LEN(K1), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .weight_start(weight_start),
    .weight_mode(weight_mode),
    .out_ch_cnt(out_ch_cnt),
    .weight3_base_addr(weight3_base_addr),
    .weight1_base_addr(weight1_base_addr),
    .weight_busy(weight_busy),
    .weight_done(weight_done),
    .weight_err(weight_err),
    .req_addr(req_addr),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .rsp_data(rsp_data),
    .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy),
    .weight_wen(weight_wen),
    .weight_waddr(weight_waddr),
    .weight_wdata(weight_wdata),
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0]        exp_req_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  int                       pend_q[$];     // cycle at which each response may be sent

  int acc_cnt, wr_cnt, done_cnt, rsp_sent, peak_out, stall_seen;
  logic [ADDR_W-1:0] first_a3, first_a1;
  bit   resp_en, rdy_rand;
  int   dly_min, dly_max;
  logic [1:0] job_mode;
  int   job_ch;
  bit   prev_stall;
  logic [ADDR_W-1:0] prev_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected %s", name, act, req);
  endtask

  // Reference buffer address for the n-th response of a job: the first K3
  // responses of a 3x3-first job are 3x3 words, the rest are 1x1 words.
  function automatic logic [ADDR_W-1:0] exp_waddr(input logic [1:0] mode, input int ch, input int n);
    int   idx;
    logic is1;
    if (mode == 2'b10) begin
      is1 = 1'b1; idx = n;
    end else if (n < K3) begin
      is1 = 1'b0; idx = n;
    end else begin
      is1 = 1'b1; idx = n - K3;
    end
    return (ADDR_W'(is1) << (ADDR_W - 1)) | (ADDR_W'(ch) << (ADDR_W - 9)) |
           ADDR_W'(idx & 16'hFFFF);
  endfunction

  // ---------------- responder and ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      if (pend_q.size() > 0 && cyc >= pend_q[0]) begin
        void'(pend_q.pop_front());
        rsp_vld  = 1'b1;
        rsp_data = $urandom;
        exp_wr_q.push_back({exp_waddr(job_mode, job_ch, rsp_sent), rsp_data});
        rsp_sent++;
      end else begin
        rsp_vld = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) req_rdy = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (req_vld && req_rdy) begin
      if (acc_cnt == 0)  first_a3 = req_addr;
      if (acc_cnt == K3) first_a1 = req_addr;
      if (exp_req_q.size() == 0) fail("req_unexpected", 128'(req_addr), "no request");
      else check("req_addr", 128'(req_addr), 128'(exp_req_q.pop_front()));
      pend_q.push_back(cyc + int'($urandom_range(dly_min, dly_max)));
      acc_cnt++;
    end
    if (prev_stall) check("req_hold", 128'({req_vld, req_addr}), 128'({1'b1, prev_addr}));
    prev_stall = req_vld && !req_rdy && !rst;
    prev_addr  = req_addr;
    if (req_vld && !req_rdy && !rst) stall_seen++;
    if (acc_cnt - rsp_sent > peak_out) peak_out = acc_cnt - rsp_sent;
    if (weight_wen) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) fail("write_unexpected", 128'(weight_waddr), "no write");
      else check("write", 128'({weight_waddr, weight_wdata}), 128'(exp_wr_q.pop_front()));
    end
    if (weight_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic flush_queues();
    exp_req_q.delete();
    exp_wr_q.delete();
    pend_q.delete();
  endtask

  task automatic begin_job(input logic [1:0] mode, input int ch,
                           input logic [ADDR_W-1:0] b3, input logic [ADDR_W-1:0] b1,
                           input int dmin, input int dmax, input bit rnd);
    @(posedge clk); #1;
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0; rsp_sent = 0; peak_out = 0; stall_seen = 0;
    job_mode = mode; job_ch = ch; dly_min = dmin; dly_max = dmax; rdy_rand = rnd;
    if (!rnd) req_rdy = 1'b1;
    if (mode[0]) for (int i = 0; i < K3; i++)
      exp_req_q.push_back(b3 + ADDR_W'(ch * K3 * BYTES) + ADDR_W'(i * BYTES));
    if (mode[1]) for (int i = 0; i < K1; i++)
      exp_req_q.push_back(b1 + ADDR_W'(ch * K1 * BYTES) + ADDR_W'(i * BYTES));
    weight_mode = mode; out_ch_cnt = 8'(ch);
    weight3_base_addr = b3; weight1_base_addr = b1;
    weight_start = 1'b1;
    @(posedge clk); #1;
    // Scramble the config inputs: the job must use the values latched at start.
    weight_start = 1'b0;
    weight_mode  = 2'($urandom_range(0, 3));
    out_ch_cnt   = 8'($urandom);
    weight3_base_addr = $urandom;
    weight1_base_addr = $urandom;
    @(negedge clk);
    check("err_cleared_by_start", 128'(weight_err), 128'(0));
    check("busy_after_start", 128'(weight_busy), 128'(1));
  endtask

  task automatic run_job(input logic [1:0] mode, input int ch,
                         input logic [ADDR_W-1:0] b3, input logic [ADDR_W-1:0] b1,
                         input int dmin, input int dmax, input bit rnd,
                         input int stall_at, input bit repulse);
    int n_exp, stall_left, t;
    bit stalled, pulsed;
    n_exp = (mode[0] ? K3 : 0) + (mode[1] ? K1 : 0);
    begin_job(mode, ch, b3, b1, dmin, dmax, rnd);
    stall_left = 0; stalled = 0; pulsed = 0; t = 0;
    while (done_cnt == 0 && t < 6000) begin
      @(posedge clk); #1;
      t++;
      weight_start = 1'b0;
      if (stall_at > 0 && !stalled && acc_cnt >= stall_at) begin
        req_rdy = 1'b0; stall_left = 5; stalled = 1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) req_rdy = 1'b1;
      end
      if (repulse && !pulsed && acc_cnt >= K3 + 6) begin
        weight_start = 1'b1; weight_mode = 2'b10; out_ch_cnt = 8'd9; pulsed = 1;
      end
    end
    weight_start = 1'b0;
    if (done_cnt == 0) fail("done_timeout", 128'(acc_cnt), "weight_done within 6000 cycles");
    repeat (3) @(negedge clk);
    check("done_pulses", 128'(done_cnt), 128'(1));
    check("write_count", 128'(wr_cnt), 128'(n_exp));
    check("req_q_empty", 128'(exp_req_q.size()), 128'(0));
    check("wr_q_empty", 128'(exp_wr_q.size()), 128'(0));
    check("busy_after_done", 128'(weight_busy), 128'(0));
    check("outst_le_max", 128'(peak_out <= MAXO), 128'(1));
    check("err_after_job", 128'(weight_err), 128'(0));
    flush_queues();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int t;
    rst = 1'b1; weight_start = 1'b0; weight_mode = 2'b00; out_ch_cnt = 8'd0;
    weight3_base_addr = '0; weight1_base_addr = '0; req_rdy = 1'b1;
    rsp_vld = 1'b0; rsp_data = '0;
    resp_en = 1'b1; rdy_rand = 1'b0; dly_min = 1; dly_max = 1;
    job_mode = 2'b01; job_ch = 0; prev_stall = 0; prev_addr = '0;
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0; rsp_sent = 0; peak_out = 0; stall_seen = 0;
    first_a3 = '0; first_a1 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_vld", 128'(req_vld), 128'(0));
    check("rst_req_addr", 128'(req_addr), 128'(0));
    check("rst_busy", 128'(weight_busy), 128'(0));
    check("rst_done", 128'(weight_done), 128'(0));
    check("rst_err", 128'(weight_err), 128'(0));
    check("rst_wen", 128'(weight_wen), 128'(0));
    check("rst_waddr", 128'(weight_waddr), 128'(0));
    check("rsp_rdy_const", 128'(rsp_rdy), 128'(1));
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    check("rst_stall_cycles", 128'(stall_cycles), 128'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Reference job: mode 11, channel 2, bases 0x1000/0x8000, 1-cycle responses.
    run_job(2'b11, 2, 32'h1000, 32'h8000, 1, 1, 0, 0, 0);
    check("first_3x3_addr", 128'(first_a3), 128'(32'h1480));
    check("first_1x1_addr", 128'(first_a1), 128'(32'h8080));

    // Slow responses: requests must stop at exactly MAXO outstanding.
    run_job(2'b10, int'($urandom_range(0, 255)), $urandom, $urandom, 10, 10, 0, 0, 0);
    check("peak_outstanding", 128'(peak_out), 128'(MAXO));

    // Ready held low for 5 cycles mid-FETCH3; req_hold checks run meanwhile.
    run_job(2'b01, int'($urandom_range(0, 255)), $urandom, $urandom, 1, 1, 0, 50, 0);
    check("stall_seen", 128'(stall_seen), 128'(5));
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    check("stall_cycles", 128'(stall_cycles), 128'(5));
`endif

    // Illegal mode 00: no job, sticky error; the next legal start clears it.
    @(posedge clk); #1;
    weight_mode = 2'b00; weight_start = 1'b1;
    @(posedge clk); #1;
    weight_start = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (weight_busy || req_vld) seen = 1;
    end
    check("mode00_err", 128'(weight_err), 128'(1));
    check("mode00_no_activity", 128'(seen), 128'(0));
    run_job(2'b10, int'($urandom_range(0, 255)), $urandom, $urandom, 1, 3, 1, 0, 0);

    // Reset after 20 accepted requests, then a late response.
    begin_job(2'b11, 7, $urandom, $urandom, 3, 3, 0);
    t = 0;
    while (acc_cnt < 20 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (acc_cnt < 20) fail("reset_wait", 128'(acc_cnt), "20 accepted requests");
    resp_en = 1'b0; rsp_vld = 1'b0; req_rdy = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(weight_busy), 128'(0));
    check("midrst_req_vld", 128'(req_vld), 128'(0));
    check("midrst_done", 128'(weight_done), 128'(0));
    flush_queues();
    @(posedge clk); #1;
    rsp_vld = 1'b1; rsp_data = $urandom;
    @(negedge clk);
    check("late_rsp_no_wen", 128'(weight_wen), 128'(0));
    @(posedge clk); #1;
    rsp_vld = 1'b0;
    @(negedge clk);
    check("late_rsp_err", 128'(weight_err), 128'(1));
    resp_en = 1'b1; req_rdy = 1'b1;

    // Start re-pulsed during FETCH1 must be ignored: 160 writes, one done.
    run_job(2'b11, int'($urandom_range(0, 255)), $urandom, $urandom, 1, 6, 0, 0, 1);

    // Randomized jobs.
    for (int j = 0; j < 3; j++) begin
      run_job(2'($urandom_range(1, 3)), int'($urandom_range(0, 255)), $urandom, $urandom,
              1, 8, 1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
